// File: rtl/instr_fetch_responder.sv
// Instruction-memory responder: fetch address in, program word out after WAIT_STATES extra cycles.
// Latency: request accepted at edge k -> Instr_Valid high for one cycle after edge k+WAIT_STATES+1.
// Backpressure: none on the response; Req is ignored while Busy and must be held or re-issued.
module instr_fetch_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1,
    parameter int NOP_WORD    = 0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req,
    input  logic [ADDR_W-1:0] Addr,
    output logic [DATA_W-1:0] Instr,
    output logic              Instr_Valid,
    output logic              Addr_Err,
    output logic              Busy,
    input  logic              Prog_We,
    input  logic [ADDR_W-1:0] Prog_Addr,
    input  logic [DATA_W-1:0] Prog_Data
);

    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]        WS_L    = 4'(WAIT_STATES);
    localparam logic [DATA_W-1:0] NOP_L   = DATA_W'(NOP_WORD);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              vld_q, vld_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word;
    logic              addr_in_range;
    logic              prog_in_range;

    assign addr_in_range = ({1'b0, addr_q} < DEPTH_L);
    assign prog_in_range = ({1'b0, Prog_Addr} < DEPTH_L);
    assign rd_word       = mem[addr_q[IDX_W-1:0]];

    // Program image: no reset init; writes blocked while reset is asserted, out-of-range dropped.
    // Read-first on collision falls out of the capture using the pre-edge array value.
    always_ff @(posedge Clk) begin
        if (Reset && Prog_We && prog_in_range) begin
            mem[Prog_Addr[IDX_W-1:0]] <= Prog_Data;
        end
    end

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            addr_q  <= '0;
            instr_q <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state: accept from IDLE/RESP, leave READ once the wait counter has run out.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (Req) state_d = S_READ;
            S_READ:  if (wcnt_q == 4'd0) state_d = S_RESP;
            S_RESP:  state_d = Req ? S_READ : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: address capture, wait countdown and response word.
    always_comb begin
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (Req) begin
                    addr_d = Addr;
                    wcnt_d = WS_L;
                end
            end
            S_READ: begin
                if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else begin
                    instr_d = addr_in_range ? rd_word : NOP_L;
                    vld_d   = 1'b1;
                    err_d   = ~addr_in_range;
                end
            end
            default: ;
        endcase
        busy_d = (state_d == S_READ);
    end

    assign Instr       = instr_q;
    assign Instr_Valid = vld_q;
    assign Addr_Err    = err_q;
    assign Busy        = busy_q;

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Bench for instr_fetch_responder: timeline reference model feeding a response scoreboard.
// Latency/throughput are checked through the expected response cycle stored with each entry.
// The monitor pops on every Instr_Valid pulse and flags missing or unexpected responses.
module tb_instr_fetch_responder;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 128;
    localparam int WS     = 1;
    localparam int NOP    = 0;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              Req;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] Instr;
    logic              Instr_Valid;
    logic              Addr_Err;
    logic              Busy;
    logic              Prog_We;
    logic [ADDR_W-1:0] Prog_Addr;
    logic [DATA_W-1:0] Prog_Data;

    instr_fetch_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .WAIT_STATES(WS), .NOP_WORD(NOP)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Addr(Addr),
        .Instr(Instr), .Instr_Valid(Instr_Valid), .Addr_Err(Addr_Err), .Busy(Busy),
        .Prog_We(Prog_We), .Prog_Addr(Prog_Addr), .Prog_Data(Prog_Data)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [DATA_W-1:0] w;
        logic              e;
        int                c;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] mem_m [256];
    logic [DATA_W-1:0] last_exp;
    int                cyc = 0;
    bit                pending = 0;
    int                cap_cyc = 0;
    int                cap_addr = 0;
    bit                mon_en = 0;
    int                n_chk = 0;
    int                n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: one fetch outstanding, answered WS+1 edges after acceptance,
    // using the memory contents as they stood before that edge's write.
    always @(posedge Clk) begin
        exp_t e;
        cyc++;
        if (!Reset) begin
            pending  = 0;
            exp_q.delete();
            last_exp = '0;
        end else begin
            if (pending && cyc == cap_cyc) begin
                e.e = (cap_addr >= DEPTH);
                e.w = e.e ? DATA_W'(NOP) : mem_m[cap_addr];
                e.c = cyc;
                exp_q.push_back(e);
                pending = 0;
            end else if (!pending && Req) begin
                pending  = 1;
                cap_cyc  = cyc + WS + 1;
                cap_addr = int'(Addr);
            end
            if (Prog_We && int'(Prog_Addr) < DEPTH) mem_m[Prog_Addr] = Prog_Data;
        end
    end

    // Monitor: scoreboard pop on each valid pulse; otherwise outputs must hold.
    always @(negedge Clk) begin
        exp_t e;
        if (mon_en) begin
            check("busy", 32'(Busy), 32'(pending));
            if (Instr_Valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(Instr_Valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_instr", 32'(Instr), 32'(e.w));
                    check("resp_addr_err", 32'(Addr_Err), 32'(e.e));
                    check("resp_cycle", 32'(cyc), 32'(e.c));
                    last_exp = e.w;
                end
            end else begin
                check("addr_err_idle", 32'(Addr_Err), 32'd0);
                check("instr_hold", 32'(Instr), 32'(last_exp));
                if (exp_q.size() > 0 && exp_q[0].c < cyc) begin
                    e = exp_q.pop_front();
                    check("missing_valid", 32'(Instr_Valid), 32'd1);
                    last_exp = e.w;
                end
            end
        end
    end

    task automatic prog(input int a, input int d);
        @(negedge Clk);
        Prog_We   = 1'b1;
        Prog_Addr = ADDR_W'(a);
        Prog_Data = DATA_W'(d);
    endtask

    task automatic prog_off();
        @(negedge Clk);
        Prog_We = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((pending || exp_q.size() != 0) && t < 60) begin
            @(negedge Clk);
            t++;
        end
        check("idle_timeout", 32'(t < 60), 32'd1);
    endtask

    task automatic wait_valid();
        int t;
        t = 0;
        do begin
            @(negedge Clk);
            t++;
        end while (!Instr_Valid && t < 20);
        check("valid_timeout", 32'(Instr_Valid), 32'd1);
    endtask

    task automatic fetch(input int a);
        @(negedge Clk);
        Req  = 1'b1;
        Addr = ADDR_W'(a);
        @(negedge Clk);
        Req  = 1'b0;
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pa;
        Reset = 1'b0; Req = 1'b0; Addr = '0;
        Prog_We = 1'b0; Prog_Addr = '0; Prog_Data = '0;
        for (int i = 0; i < 256; i++) mem_m[i] = '0;
        @(posedge Clk);
        @(negedge Clk);
        mon_en = 1;
        @(negedge Clk);
        Reset = 1'b1;
        check("rst_instr", 32'(Instr), 32'd0);
        check("rst_valid", 32'(Instr_Valid), 32'd0);
        check("rst_err", 32'(Addr_Err), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);

        // Program image: random fill, then the words the directed checks rely on.
        for (int i = 0; i < DEPTH; i++) prog(i, int'($urandom_range(0, 16'hFFFF)));
        prog(8'h05, 16'hA3C1);
        prog(8'h00, 16'h1000);
        prog(8'h01, 16'h1001);
        prog(8'h02, 16'h1002);
        prog(8'h10, 16'h1111);
        prog_off();

        // Single fetch with one wait state.
        fetch(8'h05);
        check("single_word", 32'(Instr), 32'hA3C1);

        // Back-to-back: Req held, address stepped on each response.
        @(negedge Clk);
        Req  = 1'b1;
        Addr = 8'h00;
        for (int j = 1; j <= 2; j++) begin
            wait_valid();
            Addr = ADDR_W'(j);
        end
        @(negedge Clk);
        Req = 1'b0;
        wait_idle();
        check("b2b_last", 32'(Instr), 32'h1002);

        // Out-of-range fetch and ignored out-of-range write.
        fetch(8'hC8);
        check("oor_nop", 32'(Instr), 32'(NOP));
        prog(8'hC8, 16'hFFFF);
        prog_off();
        fetch(8'h48);
        fetch(8'h00);
        check("oor_write_ignored", 32'(Instr), 32'h1000);

        // Collision: write lands on the capture edge; the old word is returned.
        @(negedge Clk);
        Req  = 1'b1;
        Addr = 8'h10;
        @(negedge Clk);
        Req = 1'b0;
        repeat (WS) @(negedge Clk);
        Prog_We   = 1'b1;
        Prog_Addr = 8'h10;
        Prog_Data = 16'h2222;
        @(negedge Clk);
        Prog_We = 1'b0;
        wait_idle();
        check("collision_old", 32'(Instr), 32'h1111);
        fetch(8'h10);
        check("collision_new", 32'(Instr), 32'h2222);

        // Random traffic; address 0x05 is left untouched for the reset check below.
        for (int i = 0; i < 300; i++) begin
            @(negedge Clk);
            Req     = ($urandom_range(0, 2) == 0);
            Addr    = ADDR_W'($urandom_range(0, 255));
            Prog_We = ($urandom_range(0, 1) == 1);
            pa      = int'($urandom_range(0, 255));
            if (pa == 5) pa = 6;
            Prog_Addr = ADDR_W'(pa);
            Prog_Data = DATA_W'($urandom_range(0, 16'hFFFF));
        end
        @(negedge Clk);
        Req = 1'b0;
        Prog_We = 1'b0;
        wait_idle();

        // Reset while in READ: fetch dropped, write during reset ignored, memory kept.
        @(negedge Clk);
        Req  = 1'b1;
        Addr = 8'h05;
        @(negedge Clk);
        Req       = 1'b0;
        Reset     = 1'b0;
        Prog_We   = 1'b1;
        Prog_Addr = 8'h05;
        Prog_Data = 16'hDEAD;
        @(negedge Clk);
        @(negedge Clk);
        Reset   = 1'b1;
        Prog_We = 1'b0;
        check("rst2_instr", 32'(Instr), 32'd0);
        check("rst2_valid", 32'(Instr_Valid), 32'd0);
        check("rst2_busy", 32'(Busy), 32'd0);
        repeat (5) @(negedge Clk);
        fetch(8'h05);
        check("mem_kept", 32'(Instr), 32'hA3C1);

        repeat (3) @(negedge Clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
